// File: rtl/fifo_1r1w_flags.sv
// Single-clock ready/valid FIFO on a synchronous-read RAM, with write-to-read bypass,
// occupancy count, almost-full/almost-empty flags, synchronous flush and high-watermark.

module ram_1r1w_sync #(
   parameter int width_p  = 8,
   parameter int addr_w_p = 4
) (
   input  logic                clk_i,
   input  logic                w_en_i,
   input  logic [addr_w_p-1:0] w_addr_i,
   input  logic [width_p-1:0]  w_data_i,
   input  logic [addr_w_p-1:0] r_addr_i,
   output logic [width_p-1:0]  r_data_o
);
   logic [width_p-1:0] mem_q [1<<addr_w_p];

   // Read returns the old contents on a same-address collision; the FIFO bypass covers that.
   always_ff @(posedge clk_i) begin
      if (w_en_i) mem_q[w_addr_i] <= w_data_i;
      r_data_o <= mem_q[r_addr_i];
   end
endmodule

module fifo_1r1w_flags #(
   parameter int width_p        = 8,
   parameter int depth_log2_p   = 4,
   parameter int almost_full_p  = (1 << depth_log2_p) - 2,
   parameter int almost_empty_p = 1
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic                    flush_i,
   input  logic [width_p-1:0]      data_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic                    valid_o,
   output logic [width_p-1:0]      data_o,
   input  logic                    ready_i,
   output logic [depth_log2_p:0]   count_o,
   output logic                    almost_full_o,
   output logic                    almost_empty_o,
   output logic [depth_log2_p:0]   hwm_o
);
   localparam int AW = depth_log2_p;
   localparam int PW = depth_log2_p + 1;
   localparam logic [PW-1:0] AF_C = PW'(almost_full_p);
   localparam logic [PW-1:0] AE_C = PW'(almost_empty_p);

   logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_n;
   logic [PW-1:0]      count_q, count_d, hwm_q, hwm_d;
   logic               byp_vld_q, byp_vld_d;
   logic [width_p-1:0] byp_data_q, ram_rdata;
   logic               full, empty, write_op, read_op, ram_we;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign ready_o  = !full;
   assign valid_o  = !empty;
   assign write_op = valid_i & ready_o;
   assign read_op  = valid_o & ready_i;

   // RAM is addressed with the post-read pointer so the new head is ready next cycle.
   assign rd_ptr_n = rd_ptr_q + PW'(read_op);
   assign ram_we   = write_op & !flush_i & reset_ni;

   always_comb begin
      wr_ptr_d  = wr_ptr_q + PW'(write_op);
      rd_ptr_d  = rd_ptr_n;
      count_d   = count_q + PW'(write_op) - PW'(read_op);
      byp_vld_d = write_op && (wr_ptr_q[AW-1:0] == rd_ptr_n[AW-1:0]);
      if (flush_i) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         byp_vld_d = 1'b0;
      end
      hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
      if (flush_i) hwm_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         hwm_q     <= '0;
         byp_vld_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         hwm_q     <= hwm_d;
         byp_vld_q <= byp_vld_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (write_op) byp_data_q <= data_i;
   end

   ram_1r1w_sync #(.width_p(width_p), .addr_w_p(AW)) u_ram (
      .clk_i    (clk_i),
      .w_en_i   (ram_we),
      .w_addr_i (wr_ptr_q[AW-1:0]),
      .w_data_i (data_i),
      .r_addr_i (rd_ptr_n[AW-1:0]),
      .r_data_o (ram_rdata)
   );

   assign data_o         = byp_vld_q ? byp_data_q : ram_rdata;
   assign count_o        = count_q;
   assign hwm_o          = hwm_q;
   assign almost_full_o  = (count_q >= AF_C);
   assign almost_empty_o = (count_q <= AE_C);
endmodule

// File: tb/tb_fifo_1r1w_flags.sv
// Scoreboard bench for fifo_1r1w_flags at depth 4: stimulus pushes expected words,
// a negedge monitor pops them on every output handshake.

module tb_fifo_1r1w_flags;
   localparam int W = 8, AWL = 2, DEPTH = 4, AF = 2, AE = 1;

   logic            clk = 1'b0, rst_n = 1'b0, flush = 1'b0, vin = 1'b0, rin = 1'b0;
   logic [W-1:0]    din = '0, dout;
   logic            rdy_o, vld_o, af_o, ae_o;
   logic [AWL:0]    cnt_o, hwm_o;

   int checks = 0, errors = 0;
   logic [W-1:0] expq[$];
   int mcnt = 0, mhwm = 0;

   always #5 clk = ~clk;

   fifo_1r1w_flags #(.width_p(W), .depth_log2_p(AWL), .almost_full_p(AF), .almost_empty_p(AE)) dut (
      .clk_i(clk), .reset_ni(rst_n), .flush_i(flush), .data_i(din), .valid_i(vin),
      .ready_o(rdy_o), .valid_o(vld_o), .data_o(dout), .ready_i(rin),
      .count_o(cnt_o), .almost_full_o(af_o), .almost_empty_o(ae_o), .hwm_o(hwm_o)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d @%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares head data whenever the consumer takes a word.
   always @(negedge clk) begin
      if (rst_n && !flush && vld_o === 1'b1 && rin) begin
         if (expq.size() == 0) chk("unexpected_output", 1, 0);
         else chk("data_o", int'(dout), int'(expq.pop_front()));
      end
   end

   // One cycle: drive inputs, check status at negedge against model, update model, pass the edge.
   task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f,
                      input logic rs = 1'b1);
      bit mw, mr;
      vin = v; din = d; rin = r; flush = f; rst_n = rs;
      @(negedge clk);
      chk("ready_o", int'(rdy_o), int'(mcnt < DEPTH));
      chk("valid_o", int'(vld_o), int'(mcnt > 0));
      chk("count_o", int'(cnt_o), mcnt);
      chk("almost_full_o", int'(af_o), int'(mcnt >= AF));
      chk("almost_empty_o", int'(ae_o), int'(mcnt <= AE));
      chk("hwm_o", int'(hwm_o), mhwm);
      if (!rs || f) begin
         expq.delete();
         mcnt = 0;
         mhwm = 0;
      end else begin
         mw = v && (mcnt < DEPTH);
         mr = r && (mcnt > 0);
         if (mw) expq.push_back(d);
         mcnt = mcnt + int'(mw) - int'(mr);
         if (mcnt > mhwm) mhwm = mcnt;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] fill_v [4];
      fill_v = '{8'h01, 8'h02, 8'h03, 8'h04};
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      // Reset state
      chk("rst_count", int'(cnt_o), 0);
      chk("rst_ready", int'(rdy_o), 1);
      chk("rst_valid", int'(vld_o), 0);
      chk("rst_ae", int'(ae_o), 1);

      // Fill then drain
      for (int i = 0; i < 4; i++) cyc(1'b1, fill_v[i], 1'b0, 1'b0);
      chk("fill_count", int'(cnt_o), 4);
      chk("fill_ready", int'(rdy_o), 0);
      chk("fill_af", int'(af_o), 1);
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_valid", int'(vld_o), 0);
      chk("drain_hwm", int'(hwm_o), 4);

      // Streaming across many pointer wraps
      for (int i = 0; i < 300; i++) cyc(1'b1, W'(i), 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // Full boundary: simultaneous valid/ready when full only reads
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h10 + W'(i), 1'b0, 1'b0);
      cyc(1'b1, 8'hEE, 1'b1, 1'b0);
      chk("full_rw_count", int'(cnt_o), 3);
      chk("full_rw_ready", int'(rdy_o), 1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // Flush with a concurrent write
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'h20 + W'(i), 1'b0, 1'b0);
      cyc(1'b1, 8'hAA, 1'b0, 1'b1);
      chk("flush_count", int'(cnt_o), 0);
      chk("flush_valid", int'(vld_o), 0);
      chk("flush_hwm", int'(hwm_o), 0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset mid-operation, then a write read back on the next cycle
      for (int i = 0; i < 2; i++) cyc(1'b1, 8'h30 + W'(i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("mid_rst_count", int'(cnt_o), 0);
      chk("mid_rst_ready", int'(rdy_o), 1);
      cyc(1'b1, 8'h5C, 1'b0, 1'b0);
      chk("post_rst_data", int'(dout), 8'h5C);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // Randomised handshakes with occasional flush
      for (int i = 0; i < 3000; i++)
         cyc(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 199) == 0));
      for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("scoreboard_empty", expq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
